// File: rtl/sepconv_16ch_stream_reader_if.sv
// Stream bundle for the 16-channel separable-convolution reader:
// the wide pixel input (no backpressure) and the serial per-channel
// output stream with its position tags and the sticky Overflow flag.
// The reader is the master of the serial stream; its consumer is the slave.
interface sepconv_16ch_stream_reader_if #(
    parameter int DATA_WIDHT = 32,
    parameter int OUT_WIDTH  = 42,
    parameter int OUT_HEIGHT = 42
) ();
    localparam int COL_W = $clog2(OUT_WIDTH);
    localparam int ROW_W = $clog2(OUT_HEIGHT);

    logic [DATA_WIDHT*16-1:0] Data_In;
    logic                     Valid_In;
    logic [DATA_WIDHT-1:0]    Out_Data;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [3:0]               Out_Channel;
    logic [COL_W-1:0]         Out_Col;
    logic [ROW_W-1:0]         Out_Row;
    logic                     Out_Last_Pixel;
    logic                     Out_Last_Frame;
    logic                     Overflow;

    modport master (
        input  Data_In,
        input  Valid_In,
        input  Out_Ready,
        output Out_Data,
        output Out_Valid,
        output Out_Channel,
        output Out_Col,
        output Out_Row,
        output Out_Last_Pixel,
        output Out_Last_Frame,
        output Overflow
    );

    modport slave (
        output Data_In,
        output Valid_In,
        output Out_Ready,
        input  Out_Data,
        input  Out_Valid,
        input  Out_Channel,
        input  Out_Col,
        input  Out_Row,
        input  Out_Last_Pixel,
        input  Out_Last_Frame,
        input  Overflow
    );
endinterface

// File: rtl/sepconv_16ch_stream_reader.sv
// sepconv_16ch_stream_reader
// Buffers whole 16-channel pixel words from the separable convolution and
// replays them one channel per beat, tagged with channel, pixel row/col,
// end-of-pixel and end-of-frame. All outputs are registered.
// Optional build macro SEPCONV_RDR_STATS_EN adds Frame_Count and
// Max_Occupancy status outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | FIFO empty, Out_Valid low
// ST_STREAM | presenting lane `lane_q` of the head pixel word
module sepconv_16ch_stream_reader #(
    parameter int DATA_WIDHT = 32,
    parameter int OUT_WIDTH  = 42,
    parameter int OUT_HEIGHT = 42,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    sepconv_16ch_stream_reader_if.master    bus
`ifdef SEPCONV_RDR_STATS_EN
    ,
    output logic [15:0]                     Frame_Count,
    output logic [$clog2(FIFO_DEPTH):0]     Max_Occupancy
`endif
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int COL_W = $clog2(OUT_WIDTH);
    localparam int ROW_W = $clog2(OUT_HEIGHT);
    localparam int PW    = DATA_WIDHT * 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       lane_q, lane_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    mem_d [FIFO_DEPTH];

    logic [DATA_WIDHT-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            out_channel_q, out_channel_d;
    logic [COL_W-1:0]      out_col_q, out_col_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic                  out_last_pixel_q, out_last_pixel_d;
    logic                  out_last_frame_q, out_last_frame_d;

    logic accept;
    logic pop;
    logic full;
    logic push;
    logic drop;
    logic col_at_end;
    logic row_at_end;

    // Handshake decode: a pop frees its slot in the same cycle, so a push
    // into a full FIFO that coincides with a pop is not a drop.
    always_comb begin
        accept     = (state_q == ST_STREAM) && bus.Out_Ready;
        pop        = accept && (lane_q == 4'hF);
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        push       = bus.Valid_In && (!full || pop);
        drop       = bus.Valid_In && full && !pop;
        col_at_end = (col_q == COL_W'(OUT_WIDTH - 1));
        row_at_end = (row_q == ROW_W'(OUT_HEIGHT - 1));
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            mem_d[wr_ptr_q] = bus.Data_In;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Lane sequencing FSM: walk lanes 0..15 of the head word, pop on lane 15.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_STREAM;
                    lane_d  = 4'd0;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (lane_q == 4'hF) begin
                        lane_d = 4'd0;
                        if (count_d == '0) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        lane_d = lane_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lane_d  = 4'd0;
            end
        endcase
    end

    // Pixel position of the head word; advances once per popped pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pop) begin
            if (col_at_end) begin
                col_d = '0;
                row_d = row_at_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Next registered output beat, derived from next-cycle state so the
    // outputs line up with the state they describe.
    always_comb begin
        out_valid_d      = (state_d == ST_STREAM);
        out_channel_d    = lane_d;
        out_col_d        = col_d;
        out_row_d        = row_d;
        out_data_d       = '0;
        out_last_pixel_d = 1'b0;
        out_last_frame_d = 1'b0;
        if (out_valid_d) begin
            out_data_d       = mem_d[rd_ptr_d][int'(lane_d)*DATA_WIDHT +: DATA_WIDHT];
            out_last_pixel_d = (lane_d == 4'hF);
            out_last_frame_d = (lane_d == 4'hF)
                               && (col_d == COL_W'(OUT_WIDTH - 1))
                               && (row_d == ROW_W'(OUT_HEIGHT - 1));
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            lane_q           <= '0;
            col_q            <= '0;
            row_q            <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            out_channel_q    <= '0;
            out_col_q        <= '0;
            out_row_q        <= '0;
            out_last_pixel_q <= 1'b0;
            out_last_frame_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            lane_q           <= lane_d;
            col_q            <= col_d;
            row_q            <= row_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            out_channel_q    <= out_channel_d;
            out_col_q        <= out_col_d;
            out_row_q        <= out_row_d;
            out_last_pixel_q <= out_last_pixel_d;
            out_last_frame_q <= out_last_frame_d;
        end
    end

    // Pixel storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.Out_Data       = out_data_q;
    assign bus.Out_Valid      = out_valid_q;
    assign bus.Out_Channel    = out_channel_q;
    assign bus.Out_Col        = out_col_q;
    assign bus.Out_Row        = out_row_q;
    assign bus.Out_Last_Pixel = out_last_pixel_q;
    assign bus.Out_Last_Frame = out_last_frame_q;
    assign bus.Overflow       = overflow_q;

`ifdef SEPCONV_RDR_STATS_EN
    logic [15:0]      frame_count_q, frame_count_d;
    logic [CNT_W-1:0] max_occ_q, max_occ_d;

    // Frame counter bumps on the accepted end-of-frame beat; peak fill
    // tracks the post-update occupancy.
    always_comb begin
        frame_count_d = frame_count_q;
        if (pop && col_at_end && row_at_end) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        max_occ_d = (count_d > max_occ_q) ? count_d : max_occ_q;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= '0;
            max_occ_q     <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            max_occ_q     <= max_occ_d;
        end
    end

    assign Frame_Count   = frame_count_q;
    assign Max_Occupancy = max_occ_q;
`endif
endmodule

// File: tb/tb_sepconv_16ch_stream_reader.sv
// Directed bench for sepconv_16ch_stream_reader using a 4x2 frame geometry
// and an 8-deep FIFO. Expected beats are queued when pixels are pushed and
// checked as the reader emits them; stalls must hold every output stable.
module tb_sepconv_16ch_stream_reader;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FD = 8;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sepconv_16ch_stream_reader_if #(.DATA_WIDHT(DW), .OUT_WIDTH(W), .OUT_HEIGHT(H)) bus ();

`ifdef SEPCONV_RDR_STATS_EN
    logic [15:0]           frame_count;
    logic [$clog2(FD):0]   max_occ;
`endif

    sepconv_16ch_stream_reader #(
        .DATA_WIDHT(DW), .OUT_WIDTH(W), .OUT_HEIGHT(H), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SEPCONV_RDR_STATS_EN
        ,
        .Frame_Count(frame_count),
        .Max_Occupancy(max_occ)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    ch;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          lp;
        logic          lf;
    } beat_t;

    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_col = 0;
    int    exp_row = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void enq_pixel(input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.data = base + DW'(k);
            b.ch   = 4'(k);
            b.col  = CW'(exp_col);
            b.row  = RW'(exp_row);
            b.lp   = (k == 15);
            b.lf   = (k == 15) && (exp_col == W - 1) && (exp_row == H - 1);
            sb.push_back(b);
        end
        if (exp_col == W - 1) begin
            exp_col = 0;
            exp_row = (exp_row == H - 1) ? 0 : exp_row + 1;
        end else begin
            exp_col = exp_col + 1;
        end
    endfunction

    // Beat monitor: compare accepted beats, require stability across stalls.
    beat_t cur, held, expb;
    bit    stalled = 1'b0;
    always @(negedge clk) begin
        cur = {bus.Out_Data, bus.Out_Channel, bus.Out_Col, bus.Out_Row,
               bus.Out_Last_Pixel, bus.Out_Last_Frame};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(bus.Out_Valid), 64'(1));
                check("stall_hold", 64'(cur), 64'(held));
            end
            if (bus.Out_Valid && bus.Out_Ready) begin
                check("beat_queued", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    expb = sb.pop_front();
                    check("beat", 64'(cur), 64'(expb));
                end
                stalled = 1'b0;
            end else if (bus.Out_Valid) begin
                stalled = 1'b1;
                held    = cur;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_pixel(input logic [DW-1:0] base, input bit drop);
        for (int k = 0; k < 16; k++) bus.Data_In[k*DW +: DW] = base + DW'(k);
        bus.Valid_In = 1'b1;
        @(posedge clk); #1;
        bus.Valid_In = 1'b0;
        if (!drop) enq_pixel(base);
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("drain_empty", 64'(sb.size()), 64'(0));
        @(negedge clk);
        check("idle_after_drain", 64'(bus.Out_Valid), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_col = 0;
        exp_row = 0;
        @(negedge clk);
        check("rst_valid", 64'(bus.Out_Valid), 64'(0));
        check("rst_overflow", 64'(bus.Overflow), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        bit found;
        bus.Data_In   = '0;
        bus.Valid_In  = 1'b0;
        bus.Out_Ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid0", 64'(bus.Out_Valid), 64'(0));
        check("rst_data0", 64'(bus.Out_Data), 64'(0));
        check("rst_tags0", 64'({bus.Out_Channel, bus.Out_Col, bus.Out_Row,
                                bus.Out_Last_Pixel, bus.Out_Last_Frame}), 64'(0));
        check("rst_overflow0", 64'(bus.Overflow), 64'(0));
        @(posedge clk); #1;

        // 1: single pixel, always ready, one-cycle latency
        bus.Out_Ready = 1'b1;
        push_pixel(32'h100, 1'b0);
        @(negedge clk);
        check("lat_not_yet", 64'(bus.Out_Valid), 64'(0));
        @(negedge clk);
        check("lat_valid", 64'(bus.Out_Valid), 64'(1));
        check("lat_lane0", 64'(bus.Out_Data), 64'(32'h100));
        drain(40);

        // 2: same word with alternating ready
        push_pixel(32'h100, 1'b0);
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            bus.Out_Ready = (i % 2 == 0);
            @(posedge clk); #1;
        end
        bus.Out_Ready = 1'b1;
        drain(8);

        // 3: nine pushes into a blocked FIFO; the ninth is dropped
        bus.Out_Ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_pixel(DW'(32'h1000 * i), 1'b0);
        check("ovf_before", 64'(bus.Overflow), 64'(0));
        push_pixel(32'h9000, 1'b1);
        check("ovf_after", 64'(bus.Overflow), 64'(1));
        bus.Out_Ready = 1'b1;
        drain(200);
        check("ovf_sticky", 64'(bus.Overflow), 64'(1));

        // 4: nine pixels across a 4x2 frame boundary
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_pixel(32'h2000_0000 + DW'(i * 32'h100), 1'b0);
            repeat (3) @(posedge clk);
            #1;
        end
        drain(200);

        // 5: push into full FIFO on the popping beat is not a drop
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 8; i++) push_pixel(32'h3000_0000 + DW'(i * 32'h100), 1'b0);
        check("t5_ovf_full", 64'(bus.Overflow), 64'(0));
        bus.Out_Ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Out_Valid && bus.Out_Channel == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_lane15_seen", 64'(found), 64'(1));
        for (int k = 0; k < 16; k++) bus.Data_In[k*DW +: DW] = 32'h3000_0800 + DW'(k);
        bus.Valid_In = 1'b1;
        @(posedge clk); #1;
        bus.Valid_In = 1'b0;
        enq_pixel(32'h3000_0800);
        check("t5_no_ovf", 64'(bus.Overflow), 64'(0));
        drain(300);

        // 6: reset mid-pixel
        push_pixel(32'h4000_0000, 1'b0);
        push_pixel(32'h4000_1000, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.Out_Valid && bus.Out_Data == 32'h4000_1005) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_lane5_seen", 64'(found), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_col = 0;
        exp_row = 0;
        @(negedge clk);
        check("t6_valid_low", 64'(bus.Out_Valid), 64'(0));
        check("t6_tags_zero", 64'({bus.Out_Channel, bus.Out_Col, bus.Out_Row}), 64'(0));
        @(posedge clk); #1;
        push_pixel(32'h5000_0000, 1'b0);
        drain(40);
        check("t6_ovf_clear", 64'(bus.Overflow), 64'(0));

`ifdef SEPCONV_RDR_STATS_EN
        // 7: statistics over two 4x2 frames, peak fill of five
        do_reset();
        check("st_fc_rst", 64'(frame_count), 64'(0));
        check("st_mo_rst", 64'(max_occ), 64'(0));
        bus.Out_Ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pixel(32'h6000_0000 + DW'(i * 32'h100), 1'b0);
        bus.Out_Ready = 1'b1;
        drain(200);
        for (int i = 5; i < 16; i++) begin
            push_pixel(32'h6000_0000 + DW'(i * 32'h100), 1'b0);
            drain(40);
        end
        check("st_frame_count", 64'(frame_count), 64'(2));
        check("st_max_occ", 64'(max_occ), 64'(5));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
